// File: rtl/pcie_rd_arb_pkg.sv
// ============================================================================
// pcie_rd_arb_pkg : shared constants and types for the PCIe read arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package pcie_rd_arb_pkg;

    localparam int NREQ = 2;

    typedef logic [$clog2(NREQ)-1:0] grant_idx_t;

    // The requester tag sits one bit above the requester-side ID.
    function automatic int tag_bit(input int iw);
        return iw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rd_outstanding_ctr.sv
// ============================================================================
// rd_outstanding_ctr : saturating up/down counter of outstanding read bursts
// Rev 1.0
// ============================================================================
`default_nettype none

module rd_outstanding_ctr #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inc,
    input  logic          dec,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] r_cnt;

    // Simultaneous inc and dec cancel; both ends saturate instead of wrapping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (inc && !dec && (r_cnt < limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (dec && !inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pcie_rd_arbiter.sv
// ============================================================================
// pcie_rd_arbiter : two-requester round-robin AXI4 read arbiter, ARID-tagged
// Optional statistics counters: define RD_ARB_STATS_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module pcie_rd_arbiter
    import pcie_rd_arb_pkg::*;
#(
    parameter int DW      = 512,
    parameter int AW      = 64,
    parameter int IW      = 4,
    parameter int MAX_OUT = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [2*AW-1:0]    S_AXI_ARADDR,
    input  logic [15:0]        S_AXI_ARLEN,
    input  logic [2*IW-1:0]    S_AXI_ARID,
    input  logic [1:0]         S_AXI_ARVALID,
    output logic [1:0]         S_AXI_ARREADY,
    output logic [DW-1:0]      S_AXI_RDATA,
    output logic [IW-1:0]      S_AXI_RID,
    output logic [1:0]         S_AXI_RRESP,
    output logic               S_AXI_RLAST,
    output logic [1:0]         S_AXI_RVALID,
    input  logic [1:0]         S_AXI_RREADY,
    output logic [AW-1:0]      M_AXI_ARADDR,
    output logic [7:0]         M_AXI_ARLEN,
    output logic [IW:0]        M_AXI_ARID,
    output logic               M_AXI_ARVALID,
    input  logic               M_AXI_ARREADY,
    input  logic [DW-1:0]      M_AXI_RDATA,
    input  logic [IW:0]        M_AXI_RID,
    input  logic [1:0]         M_AXI_RRESP,
    input  logic               M_AXI_RLAST,
    input  logic               M_AXI_RVALID,
    output logic               M_AXI_RREADY
`ifdef RD_ARB_STATS_EN
    ,
    output logic [63:0]        stat_grants,
    output logic [63:0]        stat_stalls
`endif
);

    localparam logic [7:0] c_limit = 8'(MAX_OUT);

    logic [NREQ-1:0] w_eligible;
    logic [NREQ-1:0] w_ar_hs;
    logic [NREQ-1:0] w_r_done;
    logic [7:0]      w_cnt [NREQ];
    grant_idx_t      w_grant;
    grant_idx_t      w_tag;
    grant_idx_t      r_last_grant;
    logic            r_arvalid;
    logic [AW-1:0]   r_araddr;
    logic [7:0]      r_arlen;
    logic [IW:0]     r_arid;

    assign w_tag = M_AXI_RID[tag_bit(IW)];

    always_comb begin
        w_grant = r_last_grant;
        if (&w_eligible) begin
            w_grant = ~r_last_grant;
        end else if (w_eligible[0]) begin
            w_grant = grant_idx_t'(0);
        end else if (w_eligible[1]) begin
            w_grant = grant_idx_t'(1);
        end
    end

    generate
        for (genvar n = 0; n < NREQ; n++) begin : g_req
            assign w_eligible[n]    = S_AXI_ARVALID[n] & (w_cnt[n] < c_limit);
            assign S_AXI_ARREADY[n] = resetn & ~r_arvalid & w_eligible[n]
                                      & (w_grant == grant_idx_t'(n));
            assign w_ar_hs[n]       = S_AXI_ARVALID[n] & S_AXI_ARREADY[n];
            assign S_AXI_RVALID[n]  = resetn & M_AXI_RVALID & (w_tag == grant_idx_t'(n));
            assign w_r_done[n]      = M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST
                                      & (w_tag == grant_idx_t'(n));

            rd_outstanding_ctr #(.CW(8)) u_ctr (
                .clk    (clk),
                .resetn (resetn),
                .inc    (w_ar_hs[n]),
                .dec    (w_r_done[n]),
                .limit  (c_limit),
                .cnt    (w_cnt[n])
            );

`ifdef RD_ARB_STATS_EN
            logic [31:0] r_grant_cnt;
            logic [31:0] r_stall_cnt;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_grant_cnt <= '0;
                    r_stall_cnt <= '0;
                end else begin
                    if (w_ar_hs[n]) begin
                        r_grant_cnt <= r_grant_cnt + 32'd1;
                    end
                    if (S_AXI_ARVALID[n] && !S_AXI_ARREADY[n]) begin
                        r_stall_cnt <= r_stall_cnt + 32'd1;
                    end
                end
            end

            assign stat_grants[n*32 +: 32] = r_grant_cnt;
            assign stat_stalls[n*32 +: 32] = r_stall_cnt;
`endif
        end
    endgenerate

    // ARREADY requires an empty slot, so a capture never overlaps a pending request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arid       <= '0;
            r_last_grant <= grant_idx_t'(1);
        end else if (|w_ar_hs) begin
            r_arvalid    <= 1'b1;
            r_araddr     <= S_AXI_ARADDR[int'(w_grant)*AW +: AW];
            r_arlen      <= S_AXI_ARLEN[int'(w_grant)*8 +: 8];
            r_arid       <= {w_grant, S_AXI_ARID[int'(w_grant)*IW +: IW]};
            r_last_grant <= w_grant;
        end else if (M_AXI_ARREADY) begin
            r_arvalid    <= 1'b0;
        end
    end

    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARLEN   = r_arlen;
    assign M_AXI_ARID    = r_arid;

    assign S_AXI_RDATA   = M_AXI_RDATA;
    assign S_AXI_RID     = M_AXI_RID[IW-1:0];
    assign S_AXI_RRESP   = M_AXI_RRESP;
    assign S_AXI_RLAST   = M_AXI_RLAST;
    assign M_AXI_RREADY  = resetn & S_AXI_RREADY[w_tag];

endmodule

`default_nettype wire

// File: tb/tb_pcie_rd_arbiter.sv
// ============================================================================
// tb_pcie_rd_arbiter : directed self-checking bench for pcie_rd_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pcie_rd_arbiter;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic [2*AW-1:0] s_araddr;
    logic [15:0]     s_arlen;
    logic [2*IW-1:0] s_arid;
    logic [1:0]      s_arvalid;
    logic [1:0]      s_arready;
    logic [DW-1:0]   s_rdata;
    logic [IW-1:0]   s_rid;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [1:0]      s_rvalid;
    logic [1:0]      s_rready;
    logic [AW-1:0]   m_araddr;
    logic [7:0]      m_arlen;
    logic [IW:0]     m_arid;
    logic            m_arvalid;
    logic            m_arready;
    logic [DW-1:0]   m_rdata;
    logic [IW:0]     m_rid;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic            m_rvalid;
    logic            m_rready;
`ifdef RD_ARB_STATS_EN
    logic [63:0]     stat_grants;
    logic [63:0]     stat_stalls;
`endif

    int errors;
    int checks;

    always #5 clk = ~clk;

    pcie_rd_arbiter #(.DW(DW), .AW(AW), .IW(IW), .MAX_OUT(8)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .S_AXI_ARADDR  (s_araddr),
        .S_AXI_ARLEN   (s_arlen),
        .S_AXI_ARID    (s_arid),
        .S_AXI_ARVALID (s_arvalid),
        .S_AXI_ARREADY (s_arready),
        .S_AXI_RDATA   (s_rdata),
        .S_AXI_RID     (s_rid),
        .S_AXI_RRESP   (s_rresp),
        .S_AXI_RLAST   (s_rlast),
        .S_AXI_RVALID  (s_rvalid),
        .S_AXI_RREADY  (s_rready),
        .M_AXI_ARADDR  (m_araddr),
        .M_AXI_ARLEN   (m_arlen),
        .M_AXI_ARID    (m_arid),
        .M_AXI_ARVALID (m_arvalid),
        .M_AXI_ARREADY (m_arready),
        .M_AXI_RDATA   (m_rdata),
        .M_AXI_RID     (m_rid),
        .M_AXI_RRESP   (m_rresp),
        .M_AXI_RLAST   (m_rlast),
        .M_AXI_RVALID  (m_rvalid),
        .M_AXI_RREADY  (m_rready)
`ifdef RD_ARB_STATS_EN
        ,
        .stat_grants   (stat_grants),
        .stat_stalls   (stat_stalls)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arid    = '0;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        m_rid     = '0;
        // Requests and R traffic present during reset must be gated off.
        resetn    = 1'b0;
        s_arvalid = 2'b11;
        m_rvalid  = 1'b1;
        s_rready  = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_arvalid", m_arvalid, 1'b0);
        check("rst_s_arready", s_arready, 2'b00);
        check("rst_m_rready",  m_rready,  1'b0);
        check("rst_s_rvalid",  s_rvalid,  2'b00);
        check("rst_m_arid",    m_arid,    5'h00);
        s_arvalid = 2'b00;
        m_rvalid  = 1'b0;
        s_rready  = 2'b00;
        resetn    = 1'b1;
        tick();

        // Single request from requester 0.
        s_araddr[63:0] = 64'h1000;
        s_arlen[7:0]   = 8'd3;
        s_arid[3:0]    = 4'h5;
        s_arvalid      = 2'b01;
        #1;
        check("t1_arready", s_arready, 2'b01);
        tick();
        s_arvalid = 2'b00;
        check("t1_m_arvalid", m_arvalid, 1'b1);
        check("t1_m_arid",    m_arid,    5'h05);
        check("t1_m_arlen",   m_arlen,   8'd3);
        check("t1_m_araddr",  m_araddr,  64'h1000);
        tick();
        check("t1_hold_valid", m_arvalid, 1'b1);
        check("t1_hold_addr",  m_araddr,  64'h1000);
        m_arready = 1'b1;
        tick();
        check("t1_valid_clr", m_arvalid, 1'b0);

        // Both requesting: last grant was 0, so order is 1,0,1,0.
        s_araddr[127:64] = 64'h2000;
        s_arlen[15:8]    = 8'd7;
        s_arid[7:4]      = 4'hA;
        s_arvalid        = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("t2_arready", s_arready, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            if (k == 3) s_arvalid = 2'b00;
            check("t2_m_arvalid", m_arvalid, 1'b1);
            check("t2_m_arid", m_arid, (k % 2 == 0) ? 5'h1A : 5'h05);
            tick();
        end
        // Outstanding now: req0=3, req1=2.

        s_arvalid = 2'b10;
        #1;
        for (int k = 0; k < 6; k++) begin
            check("t3_fill", s_arready, 2'b10);
            tick();
            tick();
        end
        check("t3_stall", s_arready, 2'b00);
        s_arvalid = 2'b11;
        #1;
        check("t3_req0_ok", s_arready, 2'b01);
        tick();
        s_arvalid = 2'b10;
        tick();
        check("t3_still_stall", s_arready, 2'b00);
        m_rvalid = 1'b1;
        m_rid    = 5'h13;
        m_rlast  = 1'b1;
        s_rready = 2'b10;
        #1;
        check("t3_m_rready",   m_rready,  1'b1);
        check("t3_s_rvalid",   s_rvalid,  2'b10);
        check("t3_s_rid",      s_rid,     4'h3);
        check("t3_before_dec", s_arready, 2'b00);
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        check("t3_reenable", s_arready, 2'b10);
        s_arvalid = 2'b00;
        // Outstanding now: req0=4, req1=7.

        m_rdata  = 64'hDEAD_BEEF_0123_4567;
        m_rresp  = 2'b10;
        m_rid    = 5'h12;
        m_rvalid = 1'b1;
        s_rready = 2'b01;
        #1;
        check("t4_m_rready_lo", m_rready, 1'b0);
        check("t4_s_rvalid",    s_rvalid, 2'b10);
        check("t4_s_rdata",     s_rdata,  64'hDEAD_BEEF_0123_4567);
        check("t4_s_rresp",     s_rresp,  2'b10);
        check("t4_s_rlast",     s_rlast,  1'b0);
        check("t4_s_rid",       s_rid,    4'h2);
        tick();
        s_rready = 2'b11;
        #1;
        check("t4_m_rready_hi", m_rready, 1'b1);
        check("t4_rdata_held",  s_rdata,  64'hDEAD_BEEF_0123_4567);
        tick();
        m_rid    = 5'h07;
        s_rready = 2'b10;
        #1;
        check("t4_r0_rready", m_rready, 1'b0);
        check("t4_r0_rvalid", s_rvalid, 2'b01);
        check("t4_r0_rid",    s_rid,    4'h7);
        m_rvalid = 1'b0;
        s_rready = 2'b00;

        // Same-cycle AR grant and RLAST for req0 leave its count at 4.
        s_arvalid = 2'b01;
        m_rvalid  = 1'b1;
        m_rid     = 5'h05;
        m_rlast   = 1'b1;
        s_rready  = 2'b01;
        #1;
        check("t5_arready", s_arready, 2'b01);
        check("t5_m_rready", m_rready, 1'b1);
        tick();
        s_arvalid = 2'b00;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        check("t5_m_arvalid", m_arvalid, 1'b1);
        tick();
        s_arvalid = 2'b01;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("t5_room", s_arready, 2'b01);
            tick();
            tick();
        end
        check("t5_full", s_arready, 2'b00);
        s_arvalid = 2'b00;

        // Reset while a request is pending on the master side.
        s_arvalid = 2'b10;
        m_arready = 1'b0;
        #1;
        check("t6_arready", s_arready, 2'b10);
        tick();
        s_arvalid = 2'b11;
        check("t6_pending", m_arvalid, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_arvalid", m_arvalid, 1'b0);
        check("t6_rst_arready", s_arready, 2'b00);
        check("t6_rst_araddr",  m_araddr,  64'h0);
        check("t6_rst_arid",    m_arid,    5'h00);
        tick();
        resetn = 1'b1;
        #1;
        check("t6_last_grant", s_arready, 2'b01);
        s_arvalid = 2'b00;
        // Stray RLAST for req0 at count 0 must not wrap the counter.
        m_rvalid = 1'b1;
        m_rid    = 5'h00;
        m_rlast  = 1'b1;
        s_rready = 2'b01;
        #1;
        check("t6_err_rready", m_rready, 1'b1);
        tick();
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        s_rready  = 2'b00;
        m_arready = 1'b1;
        s_arvalid = 2'b10;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("t6_req1_room", s_arready, 2'b10);
            tick();
            tick();
        end
        check("t6_req1_full", s_arready, 2'b00);
        s_arvalid = 2'b01;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("t6_req0_room", s_arready, 2'b01);
            tick();
            tick();
        end
        check("t6_req0_full", s_arready, 2'b00);
        s_arvalid = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
